// File: rtl/mem_byte_arbiter.sv
// Byte-serial memory controller: arbitrates NPORTS clients onto a byte-wide RAM/IO bus,
// sequencing 1/2/4-byte little-endian accesses and returning (sign-)extended read data.
module mem_byte_arbiter #(
    parameter int NPORTS = 2,
    parameter int ARB_RR = 0,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS-1:0]        wr_i,
    input  logic [NPORTS*ADDR_W-1:0] addr_i,
    input  logic [NPORTS*2-1:0]      size_i,
    input  logic [NPORTS-1:0]        sext_i,
    input  logic [NPORTS*32-1:0]     wdata_i,
    output logic [31:0]              rdata_o,
    output logic [NPORTS-1:0]        done_o,
    output logic [NPORTS-1:0]        grant_o,
    output logic                     busy_o,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              state_r, state_nx_s;
    logic [2:0]          cnt_r, cnt_nx_s;
    logic [2:0]          len_r, len_nx_s;
    logic                wr_r, wr_nx_s;
    logic                sext_r, sext_nx_s;
    logic [ADDR_W-1:0]   base_r, base_nx_s;
    logic [31:0]         wdata_r, wdata_nx_s;
    logic [31:0]         buf_r, buf_nx_s;
    logic [IDX_W-1:0]    last_r, last_nx_s;
    logic [NPORTS-1:0]   grant_r, grant_nx_s;
    logic [NPORTS-1:0]   done_r, done_nx_s;
    logic                busy_r, busy_nx_s;
    logic [ADDR_W-1:0]   mem_a_r, mem_a_nx_s;
    logic [7:0]          mem_dout_r, mem_dout_nx_s;
    logic [31:0]         rdata_r, rdata_nx_s;

    logic                sel_hit_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic [NPORTS-1:0]   sel_oh_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [1:0]          sel_size_s;
    logic                sel_wr_s;
    logic                sel_sext_s;
    logic [31:0]         sel_wdata_s;
    logic [31:0]         buf_cap_s;
    logic [7:0]          wbyte_s;

    function automatic logic [2:0] size_to_len(input logic [1:0] sz);
        logic [2:0] len;
        case (sz)
            2'b00:   len = 3'd1;
            2'b01:   len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [31:0] raw, input logic [2:0] len,
                                                 input logic sx);
        logic [31:0] res;
        case (len)
            3'd1:    res = {{24{sx & raw[7]}}, raw[7:0]};
            3'd2:    res = {{16{sx & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Port selection: fixed priority from index 0, or round-robin from the port after last grant
    always_comb begin : arb_comb
        int raw_v;
        int cand_v;
        raw_v      = 0;
        cand_v     = 0;
        sel_hit_s  = 1'b0;
        sel_idx_s  = {IDX_W{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            raw_v  = (ARB_RR != 0) ? (int'(last_r) + 1 + i) : i;
            cand_v = (raw_v >= NPORTS) ? (raw_v - NPORTS) : raw_v;
            if (!sel_hit_s && req_i[cand_v[IDX_W-1:0]]) begin
                sel_hit_s = 1'b1;
                sel_idx_s = cand_v[IDX_W-1:0];
            end else begin
                sel_hit_s = sel_hit_s;
            end
        end
    end

    // AND-OR mux of the selected port's request fields
    always_comb begin
        sel_oh_s    = {NPORTS{1'b0}};
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_size_s  = 2'b00;
        sel_wr_s    = 1'b0;
        sel_sext_s  = 1'b0;
        sel_wdata_s = 32'h0000_0000;
        for (int p = 0; p < NPORTS; p++) begin
            sel_oh_s[p] = (sel_idx_s == IDX_W'(p));
            sel_addr_s  = sel_addr_s  | (addr_i[p*ADDR_W +: ADDR_W] & {ADDR_W{sel_oh_s[p]}});
            sel_size_s  = sel_size_s  | (size_i[p*2 +: 2] & {2{sel_oh_s[p]}});
            sel_wr_s    = sel_wr_s    | (wr_i[p] & sel_oh_s[p]);
            sel_sext_s  = sel_sext_s  | (sext_i[p] & sel_oh_s[p]);
            sel_wdata_s = sel_wdata_s | (wdata_i[p*32 +: 32] & {32{sel_oh_s[p]}});
        end
    end

    // Byte lanes: read capture slot for the current count and next write byte to present
    always_comb begin
        buf_cap_s = buf_r;
        wbyte_s   = 8'h00;
        case (cnt_r)
            3'd1:    begin buf_cap_s[7:0]   = mem_din; wbyte_s = wdata_r[15:8];  end
            3'd2:    begin buf_cap_s[15:8]  = mem_din; wbyte_s = wdata_r[23:16]; end
            3'd3:    begin buf_cap_s[23:16] = mem_din; wbyte_s = wdata_r[31:24]; end
            3'd4:    begin buf_cap_s[31:24] = mem_din; wbyte_s = 8'h00;          end
            default: begin buf_cap_s = buf_r;          wbyte_s = 8'h00;          end
        endcase
    end

    // Next-state and datapath update; everything holds while rdy_in is low
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        len_nx_s      = len_r;
        wr_nx_s       = wr_r;
        sext_nx_s     = sext_r;
        base_nx_s     = base_r;
        wdata_nx_s    = wdata_r;
        buf_nx_s      = buf_r;
        last_nx_s     = last_r;
        grant_nx_s    = grant_r;
        done_nx_s     = done_r;
        busy_nx_s     = busy_r;
        mem_a_nx_s    = mem_a_r;
        mem_dout_nx_s = mem_dout_r;
        rdata_nx_s    = rdata_r;
        if (rdy_in) begin
            done_nx_s = {NPORTS{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (sel_hit_s) begin
                        state_nx_s    = ST_XFER;
                        cnt_nx_s      = 3'd1;
                        len_nx_s      = size_to_len(sel_size_s);
                        wr_nx_s       = sel_wr_s;
                        sext_nx_s     = sel_sext_s;
                        base_nx_s     = sel_addr_s;
                        wdata_nx_s    = sel_wdata_s;
                        buf_nx_s      = 32'h0000_0000;
                        last_nx_s     = sel_idx_s;
                        grant_nx_s    = sel_oh_s;
                        busy_nx_s     = 1'b1;
                        mem_a_nx_s    = sel_addr_s;
                        mem_dout_nx_s = sel_wdata_s[7:0];
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (!wr_r) begin
                        buf_nx_s = buf_cap_s;
                    end else begin
                        buf_nx_s = buf_r;
                    end
                    if (cnt_r < len_r) begin
                        mem_a_nx_s    = base_r + ADDR_W'(cnt_r);
                        mem_dout_nx_s = wbyte_s;
                        cnt_nx_s      = cnt_r + 3'd1;
                    end else begin
                        // Final byte: release the bus without ever presenting addr+N
                        state_nx_s    = ST_IDLE;
                        cnt_nx_s      = 3'd0;
                        done_nx_s     = grant_r;
                        grant_nx_s    = {NPORTS{1'b0}};
                        busy_nx_s     = 1'b0;
                        wr_nx_s       = 1'b0;
                        mem_a_nx_s    = {ADDR_W{1'b0}};
                        mem_dout_nx_s = 8'h00;
                        if (!wr_r) begin
                            rdata_nx_s = extend_rdata(buf_cap_s, len_r, sext_r);
                        end else begin
                            rdata_nx_s = rdata_r;
                        end
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            done_nx_s = done_r;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            len_r      <= 3'd0;
            wr_r       <= 1'b0;
            sext_r     <= 1'b0;
            base_r     <= {ADDR_W{1'b0}};
            wdata_r    <= 32'h0000_0000;
            buf_r      <= 32'h0000_0000;
            last_r     <= IDX_W'(NPORTS - 1);
            grant_r    <= {NPORTS{1'b0}};
            done_r     <= {NPORTS{1'b0}};
            busy_r     <= 1'b0;
            mem_a_r    <= {ADDR_W{1'b0}};
            mem_dout_r <= 8'h00;
            rdata_r    <= 32'h0000_0000;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            len_r      <= len_nx_s;
            wr_r       <= wr_nx_s;
            sext_r     <= sext_nx_s;
            base_r     <= base_nx_s;
            wdata_r    <= wdata_nx_s;
            buf_r      <= buf_nx_s;
            last_r     <= last_nx_s;
            grant_r    <= grant_nx_s;
            done_r     <= done_nx_s;
            busy_r     <= busy_nx_s;
            mem_a_r    <= mem_a_nx_s;
            mem_dout_r <= mem_dout_nx_s;
            rdata_r    <= rdata_nx_s;
        end
    end

    assign rdata_o  = rdata_r;
    assign done_o   = done_r;
    assign grant_o  = grant_r;
    assign busy_o   = busy_r;
    assign mem_a    = mem_a_r;
    assign mem_dout = mem_dout_r;
    assign mem_wr   = wr_r & rdy_in;

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Scoreboard bench for mem_byte_arbiter: fixed-priority instance on a RAM model plus a
// round-robin instance reading the same RAM.
module tb_mem_byte_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [1:0]  req_i, wr_i, sext_i;
    logic [63:0] addr_i, wdata_i;
    logic [3:0]  size_i;
    logic [31:0] rdata_o;
    logic [1:0]  done_o, grant_o;
    logic        busy_o;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [1:0]  rr_req;
    logic [31:0] rr_rdata;
    logic [1:0]  rr_done, rr_grant;
    logic        rr_busy;
    logic [7:0]  rr_mem_din, rr_mem_dout;
    logic [31:0] rr_mem_a;
    logic        rr_mem_wr;

    logic [7:0]  ram [0:262143];
    logic        pl_en;
    logic [17:0] pl_a;
    logic [7:0]  pl_d;
    logic [39:0] wlog_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk_in = ~clk_in;

    assign mem_din    = ram[mem_a[17:0]];
    assign rr_mem_din = ram[rr_mem_a[17:0]];

    // RAM model: preload port plus byte writes from the fixed-priority instance
    always @(posedge clk_in) begin
        if (pl_en) begin
            ram[pl_a] <= pl_d;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wlog_q.push_back({mem_a, mem_dout});
        end
    end

    mem_byte_arbiter #(.NPORTS(2), .ARB_RR(0), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i), .size_i(size_i),
        .sext_i(sext_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
        .grant_o(grant_o), .busy_o(busy_o), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_byte_arbiter #(.NPORTS(2), .ARB_RR(1), .ADDR_W(32)) dut_rr (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(rr_req), .wr_i(2'b00), .addr_i(64'h0000_0101_0000_0100), .size_i(4'b0000),
        .sext_i(2'b00), .wdata_i(64'h0), .rdata_o(rr_rdata), .done_o(rr_done),
        .grant_o(rr_grant), .busy_o(rr_busy), .mem_din(rr_mem_din), .mem_dout(rr_mem_dout),
        .mem_a(rr_mem_a), .mem_wr(rr_mem_wr)
    );

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(negedge clk_in);
        pl_en = 1'b0;
    endtask

    // Presents a request on port p and returns at the accepting clock edge
    task automatic start_req(input int p, input logic w, input logic [31:0] a,
                             input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        wr_i[p]            = w;
        addr_i[p*32 +: 32] = a;
        size_i[p*2 +: 2]   = sz;
        sext_i[p]          = sx;
        wdata_i[p*32 +: 32] = wd;
        req_i[p]           = 1'b1;
        @(posedge clk_in);
    endtask

    task automatic wait_done(input int p, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (done_o[p]) begin
                lat = i;
                break;
            end
        end
        req_i[p] = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h00 || mem_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_bus: got a=%h dout=%h wr=%b expected 0/0/0", mem_a, mem_dout, mem_wr);
        end
        n_cmp++;
        if ({done_o, grant_o, busy_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got done=%b grant=%b busy=%b expected 0", done_o, grant_o, busy_o);
        end
        n_cmp++;
        if (rdata_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 0", rdata_o);
        end
        n_cmp++;
        if ({rr_mem_a, rr_mem_dout, rr_mem_wr, rr_rdata, rr_done, rr_grant, rr_busy} !== 78'h0) begin
            n_bad++;
            $display("FAIL reset_rr: got a=%h busy=%b grant=%b expected 0", rr_mem_a, rr_busy, rr_grant);
        end
    endtask

    task automatic test_read4();
        int bad_wr = 0;
        logic [31:0] e;
        exp_q.push_back(32'h4433_2211);
        start_req(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            if (mem_wr) bad_wr++;
            n_cmp++;
            if (mem_a !== 32'h100 + k) begin
                n_bad++;
                $display("FAIL rd4_addr%0d: got %h expected %h", k, mem_a, 32'h100 + k);
            end
            if (k == 0) begin
                n_cmp++;
                if (grant_o !== 2'b01 || busy_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rd4_grant: got grant=%b busy=%b expected 01/1", grant_o, busy_o);
                end
            end
        end
        @(negedge clk_in);
        if (mem_wr) bad_wr++;
        req_i[0] = 1'b0;
        n_cmp++;
        if (done_o !== 2'b01 || busy_o !== 1'b0 || mem_a !== 32'h0) begin
            n_bad++;
            $display("FAIL rd4_done: got done=%b busy=%b a=%h expected 01/0/0", done_o, busy_o, mem_a);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata_o !== e) begin
            n_bad++;
            $display("FAIL rd4_data: got %h expected %h", rdata_o, e);
        end
        n_cmp++;
        if (bad_wr != 0) begin
            n_bad++;
            $display("FAIL rd4_nowrite: got %0d write cycles expected 0", bad_wr);
        end
    endtask

    task automatic test_write1();
        int base = wlog_q.size();
        start_req(1, 1'b1, 32'h3_0000, 2'b00, 1'b0, 32'h0000_00A5);
        @(negedge clk_in);
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3_0000, 8'hA5} || grant_o !== 2'b10) begin
            n_bad++;
            $display("FAIL wr1_bus: got wr=%b a=%h dout=%h grant=%b expected 1/30000/a5/10",
                     mem_wr, mem_a, mem_dout, grant_o);
        end
        @(negedge clk_in);
        req_i[1] = 1'b0;
        n_cmp++;
        if (done_o !== 2'b10 || mem_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL wr1_done: got done=%b wr=%b expected 10/0", done_o, mem_wr);
        end
        n_cmp++;
        if (wlog_q.size() != base + 1) begin
            n_bad++;
            $display("FAIL wr1_count: got %0d writes expected 1", wlog_q.size() - base);
        end else if (wlog_q[base] !== {32'h3_0000, 8'hA5}) begin
            n_bad++;
            $display("FAIL wr1_count: got %h expected %h", wlog_q[base], {32'h3_0000, 8'hA5});
        end
    endtask

    task automatic test_fixed_prio();
        int seen0 = 0;
        logic [31:0] e;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        wr_i = 2'b00; sext_i = 2'b00; size_i = 4'b0000;
        addr_i = 64'h0000_0101_0000_0100;
        req_i  = 2'b11;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk_in);
            if (done_o != 2'b00) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (done_o !== (2'b01 << e) || rdata_o !== ((e == 0) ? 32'h11 : 32'h22)) begin
                    n_bad++;
                    $display("FAIL fixed_order: got done=%b data=%h expected port %0d", done_o, rdata_o, e);
                end
                if (done_o[0]) begin
                    seen0++;
                    if (seen0 == 2) req_i[0] = 1'b0;
                end
                if (done_o[1]) req_i[1] = 1'b0;
            end
        end
        req_i = 2'b00;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL fixed_timeout: got %0d completions pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
        rr_req = 2'b11;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk_in);
            if (rr_done != 2'b00) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rr_done !== (2'b01 << e) || rr_rdata !== ((e == 0) ? 32'h11 : 32'h22)) begin
                    n_bad++;
                    $display("FAIL rr_order: got done=%b data=%h expected port %0d", rr_done, rr_rdata, e);
                end
            end
        end
        rr_req = 2'b00;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rr_timeout: got %0d completions pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sext();
        int lat;
        logic [31:0] e;
        for (int s = 1; s >= 0; s--) begin
            exp_q.push_back((s == 1) ? 32'hFFFF_80FF : 32'h0000_80FF);
            start_req(0, 1'b0, 32'h80FF, 2'b01, s[0], 32'h0);
            wait_done(0, 10, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat != 2 || rdata_o !== e) begin
                n_bad++;
                $display("FAIL sext%0d: got lat=%0d data=%h expected lat=2 data=%h", s, lat, rdata_o, e);
            end
        end
    endtask

    task automatic test_write_stall();
        int base = wlog_q.size();
        int lat = -1;
        int stall_bad = 0;
        start_req(0, 1'b1, 32'h0, 2'b10, 1'b0, 32'hDDCC_BBAA);
        @(negedge clk_in);
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h0, 8'hAA}) begin
            n_bad++;
            $display("FAIL stall_first: got wr=%b a=%h dout=%h expected 1/0/aa", mem_wr, mem_a, mem_dout);
        end
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk_in);
            #1;
            rdy_in = (j <= 3) ? 1'b0 : 1'b1;
            @(negedge clk_in);
            if (j <= 3 && (mem_wr !== 1'b0 || mem_a !== 32'h1)) stall_bad++;
            if (done_o[0]) begin
                lat = j;
                break;
            end
        end
        rdy_in   = 1'b1;
        req_i[0] = 1'b0;
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_bad);
        end
        n_cmp++;
        if (lat != 7) begin
            n_bad++;
            $display("FAIL stall_latency: got %0d expected 7", lat);
        end
        n_cmp++;
        if (wlog_q.size() != base + 4) begin
            n_bad++;
            $display("FAIL stall_count: got %0d writes expected 4", wlog_q.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (wlog_q[base + k] !== {32'(k), 8'hAA + 8'(k * 17)}) begin
                    n_bad++;
                    $display("FAIL stall_byte%0d: got %h expected %h", k, wlog_q[base + k],
                             {32'(k), 8'hAA + 8'(k * 17)});
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int bad_addr = 0;
        int spurious = 0;
        logic [31:0] e;
        exp_q.push_back(32'h4433_2211);
        start_req(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || grant_o !== 2'b00 || mem_wr !== 1'b0 || mem_a !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_async: got busy=%b grant=%b wr=%b a=%h expected 0", busy_o, grant_o, mem_wr, mem_a);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            if (done_o !== 2'b00) spurious++;
        end
        rst_in = 1'b0;
        @(posedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            if (done_o !== 2'b00) spurious++;
            if (mem_a !== 32'h100 + k) bad_addr++;
        end
        @(negedge clk_in);
        req_i[0] = 1'b0;
        n_cmp++;
        if (spurious != 0 || bad_addr != 0) begin
            n_bad++;
            $display("FAIL rst_restart: got %0d early done, %0d bad addr expected 0/0", spurious, bad_addr);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (done_o !== 2'b01 || rdata_o !== e) begin
            n_bad++;
            $display("FAIL rst_result: got done=%b data=%h expected 01/%h", done_o, rdata_o, e);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        pl_en  = 1'b0;
        pl_a   = 18'h0;
        pl_d   = 8'h00;
        req_i  = 2'b00;
        wr_i   = 2'b00;
        sext_i = 2'b00;
        size_i = 4'b0000;
        addr_i = 64'h0;
        wdata_i = 64'h0;
        rr_req = 2'b00;
        repeat (2) @(negedge clk_in);
        test_reset();
        poke(18'h100, 8'h11);
        poke(18'h101, 8'h22);
        poke(18'h102, 8'h33);
        poke(18'h103, 8'h44);
        poke(18'h80FF, 8'hFF);
        poke(18'h8100, 8'h80);
        rst_in = 1'b0;
        @(negedge clk_in);
        test_read4();
        test_write1();
        test_fixed_prio();
        test_round_robin();
        test_sext();
        test_write_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
